// File: rtl/mpte_fetch_stage_pkg.sv
// Shared types and constants for the MPT walk: transaction record, walk/format codes, fetch FSM states.
// Latency: n/a (types and a pure combinational address helper only).
// Backpressure: n/a.
//
// Contents: mptw_transaction_t (the walk transaction carried between stages),
// MPT index/page constants, fetch FSM state enum and the MPTE address helper.
package mpt_pkg;

    localparam int unsigned MPT_PPN_WIDTH       = 44;
    localparam int unsigned MPT_PAGE_OFFSET     = 12;
    // Each MPTE covers a 32 MiB region of supervisor physical space; one
    // 4 KiB table page holds 512 eight-byte entries.
    localparam int unsigned MPT_IDX_LSB         = 25;
    localparam int unsigned MPT_IDX_WIDTH       = 9;
    localparam int unsigned MPTE_WIDTH          = 64;
    localparam int unsigned MPT_ADDR_CALC_WIDTH = 64;

    typedef enum logic [1:0] {
        ACCESS_READ    = 2'd0,
        ACCESS_WRITE   = 2'd1,
        ACCESS_EXECUTE = 2'd2
    } mpt_access_type_t;

    typedef enum logic [1:0] {
        MPT_WALKING_ACTIVE = 2'd0,
        MPT_WALKING_SKIP   = 2'd1,
        MPT_WALKING_DONE   = 2'd2
    } mpt_walking_t;

    typedef enum logic [1:0] {
        NO_ERROR             = 2'd0,
        MPTE_FORMAT_INVALID  = 2'd1,
        MPTE_FORMAT_RESERVED = 2'd2
    } mpte_format_error_t;

    typedef struct packed {
        logic [3:0]               mode;
        logic [15:0]              sdid;
        logic [MPT_PPN_WIDTH-1:0] ppn;
    } mmpt_t;

    typedef struct packed {
        logic [63:0]             spa;
        logic [63:0]             rpa;
        mmpt_t                   mmpt;
        mpt_access_type_t        access_type;
        logic                    plb_hit;
        logic                    valid;
        mpt_walking_t            walking;
        mpte_format_error_t      format_error;
        logic                    access_error;
        logic [MPTE_WIDTH-1:0]   mpte;
    } mptw_transaction_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } mpte_fetch_state_t;

    // Byte address of the MPTE: table base page plus 8-byte entry index.
    function automatic logic [MPT_ADDR_CALC_WIDTH-1:0] mpt_entry_addr(
        input logic [MPT_PPN_WIDTH-1:0] ppn,
        input logic [MPT_IDX_WIDTH-1:0] idx
    );
        logic [MPT_ADDR_CALC_WIDTH-1:0] base;
        logic [MPT_ADDR_CALC_WIDTH-1:0] offs;
        base = MPT_ADDR_CALC_WIDTH'({ppn, {MPT_PAGE_OFFSET{1'b0}}});
        offs = MPT_ADDR_CALC_WIDTH'(idx) << 3;
        return base + offs;
    endfunction

endpackage

// File: rtl/mpte_fetch_stage_if.sv
// Handshake bundles for the fetch stage: pipeline stage link and MPT memory port.
// Latency: n/a (wires only).
// Backpressure: stage link is valid/ready; memory link is req/gnt then valid response.
//
// mpte_stage_if: valid, ready, data (master drives valid/data, slave drives ready).
// mpt_mem_if:    req/gnt/addr/we/be/wdata request channel, valid/rdata/error response.
interface mpte_stage_if
    import mpt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = $bits(mptw_transaction_t)
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

interface mpt_mem_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;

    modport master (output req, output addr, output we, output be, output wdata,
                    input gnt, input valid, input rdata, input error);
    modport slave  (input req, input addr, input we, input be, input wdata,
                    output gnt, output valid, output rdata, output error);
endinterface

// File: rtl/mpte_fetch_stage.sv
// MPT walk stage: fetches one MPTE for walking transactions, passes the rest through untouched.
// Latency: 1 cycle pass-through; 3 cycles minimum with a fetch (grant and response each add their wait).
// Backpressure: holds the transaction in OUT until master ready; slave ready only in IDLE (no bypass).
//
// Ports: clk_i, rst_i (sync, active-high); stage_slave (transaction in),
// stage_master (transaction out), mpt_master_mem (single-outstanding MPT read port).
module mpte_fetch_stage
    import mpt_pkg::*;
#(
    parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH  = $bits(mptw_transaction_t),
    parameter int unsigned PIPELINE_MASTER_DATA_WIDTH = $bits(mptw_transaction_t),
    parameter int unsigned MEMORY_DATA_WIDTH          = 64,
    parameter int unsigned MEMORY_ADDR_WIDTH          = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mpte_stage_if.slave   stage_slave,
    mpte_stage_if.master  stage_master,
    mpt_mem_if.master     mpt_master_mem
);

    mpte_fetch_state_t              r_state;
    mptw_transaction_t              r_txn;
    logic                           r_master_valid;
    logic                           r_mem_req;
    logic [MEMORY_ADDR_WIDTH-1:0]   r_mem_addr;

    mptw_transaction_t              w_in_txn;
    logic                           w_accept;
    logic                           w_fetch;

    assign w_in_txn = mptw_transaction_t'(stage_slave.data);
    assign w_accept = stage_slave.valid && stage_slave.ready;
    assign w_fetch  = w_in_txn.valid
                   && (w_in_txn.walking != MPT_WALKING_SKIP)
                   && (w_in_txn.format_error == NO_ERROR);

    // Ready is forced low during reset so nothing is accepted on the reset edge.
    assign stage_slave.ready  = (r_state == IDLE) && !rst_i;
    assign stage_master.valid = r_master_valid;
    assign stage_master.data  = PIPELINE_MASTER_DATA_WIDTH'(r_txn);

    assign mpt_master_mem.req   = r_mem_req;
    assign mpt_master_mem.addr  = r_mem_addr;
    assign mpt_master_mem.we    = 1'b0;
    assign mpt_master_mem.be    = {(MEMORY_DATA_WIDTH/8){1'b1}};
    assign mpt_master_mem.wdata = {MEMORY_DATA_WIDTH{1'b0}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_txn          <= '0;
            r_master_valid <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_txn <= w_in_txn;
                        // Decide on the incoming word so the request (or the
                        // pass-through output) is already registered next cycle.
                        if (w_fetch) begin
                            r_state    <= REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= MEMORY_ADDR_WIDTH'(mpt_entry_addr(
                                              w_in_txn.mmpt.ppn,
                                              w_in_txn.spa[MPT_IDX_LSB +: MPT_IDX_WIDTH]));
                        end else begin
                            r_state        <= OUT;
                            r_master_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Address is left untouched after the grant; only req drops.
                    if (mpt_master_mem.gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mpt_master_mem.valid) begin
                        r_txn.mpte <= MPTE_WIDTH'(mpt_master_mem.rdata);
                        if (mpt_master_mem.error) begin
                            r_txn.access_error <= 1'b1;
                            r_txn.walking      <= MPT_WALKING_SKIP;
                        end else if (!mpt_master_mem.rdata[0]) begin
                            r_txn.format_error <= MPTE_FORMAT_INVALID;
                            r_txn.walking      <= MPT_WALKING_SKIP;
                        end
                        r_state        <= OUT;
                        r_master_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (stage_master.ready) begin
                        r_master_valid <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
